spikecore_fifo: RTL and testbench

SPIKECORE_FIFO -- requirements
Module: spikecore_fifo

---
 rtl/spikecore_fifo.sv | 130 +++++++++++++
 tb/tb_spikecore_fifo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spikecore_fifo.sv
// Spike address FIFO with a two-state frame handshake.
// A producer pushes spike addresses while the frame is collecting. frame_end_i
// closes the frame, and the consumer then drains the FIFO. tick_done_i throws
// away anything left over and reopens the FIFO for the next tick.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_COLLECT | frame open, pushes accepted
// ST_READY   | frame closed, pushes refused, consumer drains
module spikecore_fifo #(
  parameter int N     = 256,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(N),
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          spk_valid_i,
  input  logic [AW-1:0] spk_addr_i,
  output logic          spk_ready_o,
  input  logic          frame_end_i,
  input  logic          tick_done_i,
  input  logic          clear_i,
  input  logic          r_en_i,
  output logic [AW-1:0] r_data_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          done_o,
  output logic [CW-1:0] count_o,
  output logic          underflow_o
);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_READY   = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] r_data_q, r_data_d;
  logic          underflow_q, underflow_d;
  logic [AW-1:0] mem [DEPTH];
  logic          push, pop;

  // Status flags come straight from the registered count. Ready ignores
  // r_en_i on purpose, so a pop never frees a slot for a push in the same cycle.
  always_comb begin
    empty_o     = (count_q == '0);
    full_o      = (count_q == CW'(DEPTH));
    spk_ready_o = (state_q == ST_COLLECT) && !full_o;
    done_o      = (state_q == ST_READY);
    push        = spk_valid_i && spk_ready_o;
    pop         = r_en_i && !empty_o;
    count_o     = count_q;
    r_data_o    = r_data_q;
    underflow_o = underflow_q;
  end

  // Next-state logic. clear_i overrides everything. Otherwise the pop and push
  // are applied first, then the frame handshake. tick_done_i discards whatever
  // the consumer has not popped.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    r_data_d    = r_data_q;
    underflow_d = underflow_q;
    if (clear_i) begin
      state_d     = ST_COLLECT;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      r_data_d    = '0;
      underflow_d = 1'b0;
    end else begin
      if (pop) begin
        r_data_d = mem[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else if (r_en_i) begin
        underflow_d = 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
      if (state_q == ST_COLLECT) begin
        if (frame_end_i) state_d = ST_READY;
      end else if (tick_done_i) begin
        state_d  = ST_COLLECT;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end
    end
  end

  // Control registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= ST_COLLECT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      r_data_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      r_data_q    <= r_data_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array has no reset. Only the pointers and count say which entries
  // are valid.
  always_ff @(posedge CLK) begin
    if (push && !clear_i) begin
      mem[wr_ptr_q] <= spk_addr_i;
    end
  end

endmodule

// File: tb/tb_spikecore_fifo.sv
// Randomised scoreboard bench for spikecore_fifo.
// The model is a queue of addresses plus a frame flag. Expected pop data is
// queued when the pop is issued. A monitor compares it after the edge.
module tb_spikecore_fifo;
  localparam int N     = 256;
  localparam int DEPTH = 32;
  localparam int AW    = 8;
  localparam int CW    = 6;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          spk_valid_i, frame_end_i, tick_done_i, clear_i, r_en_i;
  logic [AW-1:0] spk_addr_i;
  logic          spk_ready_o, empty_o, full_o, done_o, underflow_o;
  logic [AW-1:0] r_data_o;
  logic [CW-1:0] count_o;

  int compared   = 0;
  int mismatched = 0;
  int max_cnt    = 0;

  logic [AW-1:0] m_q[$];
  logic [AW-1:0] exp_q[$];
  logic          m_ready_st;
  logic          m_uf;
  logic [AW-1:0] m_rdata;
  logic          ren_s = 1'b0;

  spikecore_fifo #(.N(N), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .spk_valid_i(spk_valid_i), .spk_addr_i(spk_addr_i), .spk_ready_o(spk_ready_o),
    .frame_end_i(frame_end_i), .tick_done_i(tick_done_i), .clear_i(clear_i),
    .r_en_i(r_en_i), .r_data_o(r_data_o), .empty_o(empty_o), .full_o(full_o),
    .done_o(done_o), .count_o(count_o), .underflow_o(underflow_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ready_st = 1'b0;
    m_uf       = 1'b0;
    m_rdata    = '0;
  endtask

  task automatic check_status();
    chk("count_o", 32'(count_o), 32'(m_q.size()));
    chk("empty_o", 32'(empty_o), 32'(m_q.size() == 0));
    chk("full_o", 32'(full_o), 32'(m_q.size() == DEPTH));
    chk("done_o", 32'(done_o), 32'(m_ready_st));
    chk("underflow_o", 32'(underflow_o), 32'(m_uf));
  endtask

  task automatic check_reset_values();
    chk("rst spk_ready_o", 32'(spk_ready_o), 32'd1);
    chk("rst empty_o", 32'(empty_o), 32'd1);
    chk("rst full_o", 32'(full_o), 32'd0);
    chk("rst done_o", 32'(done_o), 32'd0);
    chk("rst count_o", 32'(count_o), 32'd0);
    chk("rst underflow_o", 32'(underflow_o), 32'd0);
    chk("rst r_data_o", 32'(r_data_o), 32'd0);
  endtask

  // One clock cycle: drive inputs, check ready, advance the model, clock, check status.
  task automatic cyc(input logic v, input logic [AW-1:0] a, input logic fe,
                     input logic td, input logic clr, input logic ren);
    logic exp_ready;
    spk_valid_i = v; spk_addr_i = a; frame_end_i = fe;
    tick_done_i = td; clear_i = clr; r_en_i = ren;
    #1;
    exp_ready = !m_ready_st && (m_q.size() < DEPTH);
    chk("spk_ready_o", 32'(spk_ready_o), 32'(exp_ready));
    if (clr) begin
      model_reset();
    end else begin
      if (ren && m_q.size() > 0) m_rdata = m_q.pop_front();
      else if (ren) m_uf = 1'b1;
      if (v && exp_ready) m_q.push_back(a);
      if (!m_ready_st && fe) m_ready_st = 1'b1;
      else if (m_ready_st && td) begin
        m_ready_st = 1'b0;
        m_q.delete();
      end
    end
    if (ren) exp_q.push_back(m_rdata);
    if (m_q.size() > max_cnt) max_cnt = m_q.size();
    @(posedge CLK);
    #1;
    spk_valid_i = 0; frame_end_i = 0; tick_done_i = 0; clear_i = 0; r_en_i = 0;
    check_status();
  endtask

  // Monitor: after every edge that sampled r_en_i, r_data_o must equal the next queued value.
  initial begin
    forever begin
      @(posedge CLK);
      ren_s = r_en_i;
      @(negedge CLK);
      if (ren_s) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL r_data_o: got %0d with no expected entry at %0t", r_data_o, $time);
        end else begin
          chk("r_data_o", 32'(r_data_o), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] held;
    RSTN = 1'b0;
    spk_valid_i = 0; spk_addr_i = '0; frame_end_i = 0;
    tick_done_i = 0; clear_i = 0; r_en_i = 0;
    model_reset();
    #2;
    check_reset_values();
    #10 RSTN = 1'b1;
    @(posedge CLK); #1;

    // Basic frame
    cyc(1, 8'd5, 0, 0, 0, 0);
    cyc(1, 8'd9, 0, 0, 0, 0);
    cyc(1, 8'd200, 0, 0, 0, 0);
    cyc(0, 8'd0, 1, 0, 0, 0);
    chk("basic done_o", 32'(done_o), 32'd1);
    for (int i = 0; i < 3; i++) cyc(0, 8'd0, 0, 0, 0, 1);
    chk("basic empty_o", 32'(empty_o), 32'd1);
    cyc(0, 8'd0, 0, 1, 0, 0);
    chk("basic done after tick", 32'(done_o), 32'd0);

    // Full, including the 33rd push with a simultaneous pop
    for (int i = 0; i < DEPTH; i++) cyc(1, AW'($urandom), 0, 0, 0, 0);
    chk("full_o at 32", 32'(full_o), 32'd1);
    chk("spk_ready_o at 32", 32'(spk_ready_o), 32'd0);
    cyc(1, AW'($urandom), 0, 0, 0, 1);
    for (int i = 0; i < DEPTH - 1; i++) cyc(0, 8'd0, 0, 0, 0, 1);
    chk("full drained", 32'(empty_o), 32'd1);

    // Wrap-around
    max_cnt = 0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 20; i++) cyc(1, AW'($urandom), 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) cyc(0, 8'd0, 0, 0, 0, 1);
    end
    chk("wrap max count", 32'(max_cnt), 32'd20);

    // Pop while empty
    held = r_data_o;
    cyc(0, 8'd0, 0, 0, 0, 1);
    chk("underflow hold r_data_o", 32'(r_data_o), 32'(held));
    chk("underflow set", 32'(underflow_o), 32'd1);
    cyc(0, 8'd0, 0, 0, 1, 0);
    chk("clear underflow", 32'(underflow_o), 32'd0);
    chk("clear r_data_o", 32'(r_data_o), 32'd0);

    // Tick discard and READY lockout
    for (int i = 0; i < 4; i++) cyc(1, AW'($urandom), 0, 0, 0, 0);
    cyc(0, 8'd0, 1, 0, 0, 0);
    cyc(1, 8'd77, 0, 0, 0, 0);
    cyc(0, 8'd0, 0, 0, 0, 1);
    chk("ready lockout count", 32'(count_o), 32'd3);
    cyc(0, 8'd0, 0, 1, 0, 0);
    chk("discard count_o", 32'(count_o), 32'd0);
    chk("discard done_o", 32'(done_o), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 4) != 0, AW'($urandom), ($urandom % 16) == 0,
          ($urandom % 8) == 0, ($urandom % 64) == 0, ($urandom % 3) == 0);
    cyc(0, 8'd0, 0, 0, 1, 0);

    // Asynchronous reset with 7 entries in READY
    for (int i = 0; i < 7; i++) cyc(1, AW'($urandom), 0, 0, 0, 0);
    cyc(0, 8'd0, 1, 0, 0, 0);
    chk("pre-reset count_o", 32'(count_o), 32'd7);
    #2 RSTN = 1'b0;
    #1;
    model_reset();
    check_reset_values();
    #3 RSTN = 1'b1;
    @(posedge CLK); #1;
    cyc(1, 8'd42, 0, 0, 0, 0);
    cyc(0, 8'd0, 0, 0, 0, 1);
    cyc(0, 8'd0, 0, 0, 0, 0);

    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard drain: got %0d leftover expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
